// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requester engines, the arbiter
// and the FIFO manager write port.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            i_req_vld;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ-1:0]            o_req_rdy;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_fifo_wr;
  logic [DATA_WIDTH-1:0]         o_fifo_data;
  logic                          i_fifo_full;
  logic                          i_fifo_a_full;
  logic                          o_busy;
  logic [CNT_WIDTH-1:0]          o_stall_cnt;

  modport slave (
    input  i_req_vld, i_req_data, i_req_last,
    input  i_fifo_full, i_fifo_a_full,
    output o_req_rdy, o_grant, o_fifo_wr,
    output o_fifo_data, o_busy, o_stall_cnt
  );

  modport master (
    output i_req_vld, i_req_data, i_req_last,
    output i_fifo_full, i_fifo_a_full,
    input  o_req_rdy, o_grant, o_fifo_wr,
    input  o_fifo_data, o_busy, o_stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter in front of the FIFO write port,
// with a one-beat output register that holds while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nx;
  logic [NUM_REQ-1:0]    grant, grant_nx;
  logic [IW-1:0]         gidx, gidx_nx;
  logic [IW-1:0]         last, last_nx;
  logic [BW-1:0]         beats, beats_nx, beats_inc;
  logic                  wr;
  logic [DATA_WIDTH-1:0] data;
  logic [CNT_WIDTH-1:0]  stall;

  logic                  stage_free;
  logic [NUM_REQ-1:0]    rdy;
  logic                  xfer;
  logic                  hit;
  logic [IW-1:0]         win;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  assign stage_free = !wr || !bus.i_fifo_full;
  assign rdy        = (state == BURST && stage_free) ? grant : '0;
  assign xfer       = |(bus.i_req_vld & rdy);
  assign beats_inc  = beats + 1'b1;

  // first valid requester after the last one served, wrapping
  always_comb begin
    hit = 1'b0;
    win = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!hit && bus.i_req_vld[IW'((int'(last) + i) % NUM_REQ)]) begin
        hit = 1'b1;
        win = IW'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gidx == IW'(k)) begin
        sel_data = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last = bus.i_req_last[k];
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    gidx_nx  = gidx;
    last_nx  = last;
    beats_nx = beats;
    unique case (state)
      IDLE: begin
        if (hit && !bus.i_fifo_a_full) begin
          state_nx = BURST;
          gidx_nx  = win;
          grant_nx = NUM_REQ'(1) << win;
          beats_nx = '0;
        end else begin
          grant_nx = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          beats_nx = beats_inc;
          if (sel_last || beats_inc == BW'(MAX_BURST)) begin
            state_nx = IDLE;
            last_nx  = gidx;
            grant_nx = '0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IW'(NUM_REQ - 1);
      beats <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      gidx  <= gidx_nx;
      last  <= last_nx;
      beats <= beats_nx;
    end
  end

  // held beat is dropped on reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr    <= 1'b0;
      data  <= '0;
      stall <= '0;
    end else begin
      if (xfer) begin
        wr   <= 1'b1;
        data <= sel_data;
      end else if (stage_free) begin
        wr   <= 1'b0;
      end
      if (wr && bus.i_fifo_full && stall != '1) begin
        stall <= stall + 1'b1;
      end
    end
  end

  assign bus.o_req_rdy   = rdy;
  assign bus.o_grant     = grant;
  assign bus.o_fifo_wr   = wr;
  assign bus.o_fifo_data = data;
  assign bus.o_busy      = (state == BURST) || wr;
  assign bus.o_stall_cnt = stall;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle tables plus
// hand sequences for burst cap, full stall, almost-full, reset.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic        full;
    logic        afull;
    logic [11:0] d;
    logic [3:0]  rdy;
    logic [3:0]  grant;
    logic        wr;
    logic [15:0] fdata;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic [3:0] vld, logic [3:0] last, logic full, logic afull,
    logic [11:0] d, logic [3:0] rdy, logic [3:0] grant,
    logic wr, logic [15:0] fdata, logic busy);
    vec_t v;
    v.vld = vld; v.last = last; v.full = full; v.afull = afull;
    v.d = d; v.rdy = rdy; v.grant = grant; v.wr = wr;
    v.fdata = fdata; v.busy = busy;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int k, logic [15:0] v);
    bus.i_req_data[k*DW +: DW] = v;
  endtask

  task automatic idle_inputs();
    bus.i_req_vld     = '0;
    bus.i_req_last    = '0;
    bus.i_req_data    = '0;
    bus.i_fifo_full   = 1'b0;
    bus.i_fifo_a_full = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst.grant", 32'(bus.o_grant), 32'h0);
    chk("rst.wr", 32'(bus.o_fifo_wr), 32'h0);
    chk("rst.data", 32'(bus.o_fifo_data), 32'h0);
    chk("rst.stall", 32'(bus.o_stall_cnt), 32'h0);
    chk("rst.busy", 32'(bus.o_busy), 32'h0);
    chk("rst.rdy", 32'(bus.o_req_rdy), 32'h0);
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      if (i > lo) cyc();
      bus.i_req_vld     = tbl[i].vld;
      bus.i_req_last    = tbl[i].last;
      bus.i_fifo_full   = tbl[i].full;
      bus.i_fifo_a_full = tbl[i].afull;
      for (int k = 0; k < NR; k++) set_lane(k, {4'(k), tbl[i].d});
      #1;
      chk($sformatf("row%0d.rdy", i), 32'(bus.o_req_rdy), 32'(tbl[i].rdy));
      chk($sformatf("row%0d.grant", i), 32'(bus.o_grant), 32'(tbl[i].grant));
      chk($sformatf("row%0d.wr", i), 32'(bus.o_fifo_wr), 32'(tbl[i].wr));
      chk($sformatf("row%0d.busy", i), 32'(bus.o_busy), 32'(tbl[i].busy));
      if (tbl[i].wr)
        chk($sformatf("row%0d.data", i), 32'(bus.o_fifo_data), 32'(tbl[i].fdata));
    end
  endtask

  task automatic build_tables(output int rr_lo, output int rr_hi);
    int r;
    int p;
    logic [3:0] oh;
    // single requester: A,B,C from requester 0
    tbl.push_back(mk(4'h1, 4'h0, 0, 0, 12'h00A, 4'h0, 4'h0, 0, 16'h0000, 0));
    tbl.push_back(mk(4'h1, 4'h0, 0, 0, 12'h00A, 4'h1, 4'h1, 0, 16'h0000, 1));
    tbl.push_back(mk(4'h1, 4'h0, 0, 0, 12'h00B, 4'h1, 4'h1, 1, 16'h000A, 1));
    tbl.push_back(mk(4'h1, 4'h1, 0, 0, 12'h00C, 4'h1, 4'h1, 1, 16'h000B, 1));
    tbl.push_back(mk(4'h0, 4'h0, 0, 0, 12'h000, 4'h0, 4'h0, 1, 16'h000C, 1));
    tbl.push_back(mk(4'h0, 4'h0, 0, 0, 12'h000, 4'h0, 4'h0, 0, 16'h0000, 0));
    // round robin, everyone valid, bursts of two
    rr_lo = tbl.size();
    for (int b = 0; b < 5; b++) begin
      r  = b % 4;
      p  = (b + 3) % 4;
      oh = 4'(1 << r);
      tbl.push_back(mk(4'hF, 4'h0, 0, 0, 12'(3*b), 4'h0, 4'h0,
                       1'(b > 0), {4'(p), 12'(3*b - 1)}, 1'(b > 0)));
      tbl.push_back(mk(4'hF, 4'h0, 0, 0, 12'(3*b + 1), oh, oh,
                       0, 16'h0000, 1));
      tbl.push_back(mk(4'hF, 4'hF, 0, 0, 12'(3*b + 2), oh, oh,
                       1, {4'(r), 12'(3*b + 1)}, 1));
    end
    tbl.push_back(mk(4'h0, 4'h0, 0, 0, 12'd15, 4'h0, 4'h0, 1, {4'h0, 12'd14}, 1));
    tbl.push_back(mk(4'h0, 4'h0, 0, 0, 12'd16, 4'h0, 4'h0, 0, 16'h0000, 0));
    rr_hi = tbl.size();
  endtask

  task automatic test_cap();
    int sent;
    int recv;
    int run;
    int runs[$];
    sent = 0;
    recv = 0;
    run  = 0;
    do_reset();
    for (int c = 0; c < 80; c++) begin
      cyc();
      if (bus.o_fifo_wr) begin
        chk("cap.data", 32'(bus.o_fifo_data), 32'({4'h2, 12'(recv)}));
        recv++;
        run++;
      end else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
      if (recv == 20 && run == 0) break;
      bus.i_req_vld = (sent < 20) ? 4'h4 : 4'h0;
      set_lane(2, {4'h2, 12'(sent)});
      #1;
      if (bus.i_req_vld[2] && bus.o_req_rdy[2]) sent++;
    end
    chk("cap.beats", 32'(recv), 32'd20);
    chk("cap.nbursts", 32'(runs.size()), 32'd3);
    if (runs.size() == 3) begin
      chk("cap.burst0", 32'(runs[0]), 32'd8);
      chk("cap.burst1", 32'(runs[1]), 32'd8);
      chk("cap.burst2", 32'(runs[2]), 32'd4);
    end
  endtask

  task automatic test_stall();
    int sent;
    int recv;
    int left;
    int kind;
    int k;
    logic d55;
    logic d57;
    logic pend;
    logic wr;
    logic [15:0] trig;
    logic [15:0] fd;
    logic [CW-1:0] sc;
    sent = 0; recv = 0; left = 0; kind = 0; k = 0;
    d55 = 0; d57 = 0; pend = 0; trig = '0; sc = '0;
    do_reset();
    for (int c = 0; c < 80 && recv < 10; c++) begin
      cyc();
      wr = bus.o_fifo_wr;
      fd = bus.o_fifo_data;
      if (pend) begin
        chk($sformatf("stall%0d.cnt_delta", kind),
            32'(bus.o_stall_cnt - sc), (kind == 1) ? 32'd5 : 32'd3);
        pend = 1'b0;
      end
      if (left == 0 && wr && fd == 16'h0055 && !d55) begin
        d55 = 1'b1; left = 5; kind = 1; k = 0; trig = fd;
        sc = bus.o_stall_cnt;
        chk("stall.cnt_pre", 32'(sc), 32'd0);
      end else if (left == 0 && wr && fd == 16'h0057 && !d57) begin
        d57 = 1'b1; left = 3; kind = 2; k = 0; trig = fd;
        sc = bus.o_stall_cnt;
      end
      bus.i_fifo_full = (left > 0);
      if (left > 0 && k > 0) begin
        chk("stall.hold", 32'(fd), 32'(trig));
        chk("stall.wr", 32'(wr), 32'd1);
      end
      if (wr && left == 0) begin
        chk("stall.order", 32'(fd), 32'(16'h0050 + 16'(recv)));
        recv++;
      end
      bus.i_req_vld  = (sent < 10) ? 4'h2 : 4'h0;
      bus.i_req_last = (sent == 9) ? 4'h2 : 4'h0;
      set_lane(1, 16'h0050 + 16'(sent));
      #1;
      if (left > 0) begin
        chk("stall.rdy", 32'(bus.o_req_rdy), 32'h0);
        if (kind == 2 && k > 0) begin
          chk("stall.regrant", 32'(bus.o_grant), 32'h2);
          chk("stall.busy", 32'(bus.o_busy), 32'h1);
        end
        left--;
        k++;
        if (left == 0) pend = 1'b1;
      end
      if (bus.i_req_vld[1] && bus.o_req_rdy[1]) sent++;
    end
    chk("stall.recv", 32'(recv), 32'd10);
    chk("stall.sent", 32'(sent), 32'd10);
    chk("stall.total", 32'(bus.o_stall_cnt), 32'd8);
    idle_inputs();
  endtask

  task automatic test_afull();
    do_reset();
    bus.i_req_vld     = 4'h1;
    bus.i_fifo_a_full = 1'b1;
    repeat (3) begin
      cyc();
      chk("afull.hold", 32'(bus.o_grant), 32'h0);
    end
    cyc();
    bus.i_fifo_a_full = 1'b0;
    #1;
    chk("afull.hold", 32'(bus.o_grant), 32'h0);
    cyc();
    bus.i_fifo_a_full = 1'b1;
    #1;
    chk("afull.grant", 32'(bus.o_grant), 32'h1);
    chk("afull.rdy0", 32'(bus.o_req_rdy), 32'h1);
    for (int j = 1; j < 4; j++) begin
      cyc();
      bus.i_req_last = (j == 3) ? 4'h1 : 4'h0;
      #1;
      chk($sformatf("afull.rdy%0d", j), 32'(bus.o_req_rdy), 32'h1);
    end
    cyc();
    bus.i_req_last = 4'h0;
    bus.i_req_vld  = 4'h0;
    #1;
    chk("afull.end_grant", 32'(bus.o_grant), 32'h0);
    chk("afull.end_wr", 32'(bus.o_fifo_wr), 32'h1);
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.i_req_vld = 4'h2;
    set_lane(1, 16'h0100);
    cyc();
    #1;
    chk("mrst.grant", 32'(bus.o_grant), 32'h2);
    cyc();
    cyc();
    chk("mrst.wr_pre", 32'(bus.o_fifo_wr), 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.i_req_vld = 4'h3;
    #1;
    chk("mrst.grant0", 32'(bus.o_grant), 32'h0);
    chk("mrst.wr0", 32'(bus.o_fifo_wr), 32'h0);
    chk("mrst.data0", 32'(bus.o_fifo_data), 32'h0);
    chk("mrst.busy0", 32'(bus.o_busy), 32'h0);
    chk("mrst.rdy0", 32'(bus.o_req_rdy), 32'h0);
    cyc();
    #1;
    chk("mrst.regrant", 32'(bus.o_grant), 32'h1);
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_lo;
    int rr_hi;
    idle_inputs();
    build_tables(rr_lo, rr_hi);
    do_reset();
    run_rows(0, rr_lo);
    do_reset();
    run_rows(rr_lo, rr_hi);
    test_cap();
    test_stall();
    test_afull();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of the team's FIFO manager between `NUM_REQ` requesters. Grants one requester at a time for a burst of up to `MAX_BURST` beats. Honours the FIFO's full and almost-full flags and holds the registered write beat whenever the FIFO reports full, so no beat is ever lost. Sits between producer engines and the FIFO manager's write interface, in the FIFO write clock domain.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 512: beat width; matches the FIFO data width.
- `MAX_BURST`, 8: maximum beats per grant, 1..256.
- `CNT_WIDTH`, 16: width of the stall counter.

- `i_clk`  in  1  clock; the FIFO write clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req_vld`  in  NUM_REQ  per-requester beat valid.
- `i_req_data`  in  NUM_REQ*DATA_WIDTH  per-requester beat; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `i_req_last`  in  NUM_REQ  per-requester end-of-burst marker.
- `o_req_rdy`  out  NUM_REQ  per-requester ready; combinational.
- `o_grant`  out  NUM_REQ  one-hot current grant, registered; zero when idle.
- `o_fifo_wr`  out  1  write strobe to the FIFO, registered.
- `o_fifo_data`  out  DATA_WIDTH  write data to the FIFO, registered.
- `i_fifo_full`  in  1  FIFO full flag.
- `i_fifo_a_full`  in  1  FIFO almost-full flag.
- `o_busy`  out  1  high in BURST or while `o_fifo_wr` is pending.
- `o_stall_cnt`  out  CNT_WIDTH  saturating count of cycles with `o_fifo_wr` high and `i_fifo_full` high.

## Operation
**Reset values**
- `o_grant`=0, `o_fifo_wr`=0, `o_fifo_data`=0, `o_stall_cnt`=0, `o_busy`=0, state=IDLE.
- Last-served pointer = NUM_REQ-1, so requester 0 wins first.

**Output register (one-beat pipeline stage)**
- The beat is consumed when `o_fifo_wr`=1 and `i_fifo_full`=0.
- Stage free = `o_fifo_wr`=0 or `i_fifo_full`=0.
- `o_req_rdy[k]` = `o_grant[k]` & state==BURST & stage free.
- Transfer occurs on `i_req_vld[k]` & `o_req_rdy[k]`. The stage loads that beat and sets `o_fifo_wr`=1.
- If the stage is free and there is no transfer, `o_fifo_wr` clears to 0.
- If `o_fifo_wr`=1 and `i_fifo_full`=1, `o_fifo_wr` and `o_fifo_data` hold unchanged.

**State machine**
- IDLE:
  - Leaves when any `i_req_vld` is high and `i_fifo_a_full`=0.
  - Winner is the first valid requester scanning from last-served+1, wrapping modulo NUM_REQ.
  - `o_grant` is set to the winner's one-hot value and the beat counter is set to 0.
  - Otherwise stays in IDLE with `o_grant`=0.
- BURST:
  - Each transfer increments the beat counter, which is ceil(log2(MAX_BURST+1)) bits wide.
  - Leaves to IDLE on a transfer with `i_req_last`=1, or on the transfer that makes the count equal MAX_BURST.
  - On exit: last-served = granted index, `o_grant`=0.
  - A requester deasserting `i_req_vld` mid-burst does not end the grant.
  - `i_fifo_a_full` is ignored inside BURST; only `i_fifo_full` stalls.
- The mandatory IDLE cycle between bursts is the arbitration bubble.

**Stall counter**
- Increments when `o_fifo_wr`=1 and `i_fifo_full`=1.
- Saturates at 2^CNT_WIDTH-1.
- Cleared only by reset.

**Boundary conditions**
- A full FIFO during the final beat still lets the FSM return to IDLE. The pending beat stays held and `o_busy` stays high.
- A new grant may be issued while an earlier beat is still held. Its requester sees `o_req_rdy`=0 until the stage frees.
- `i_rst` asserted mid-burst:
  - returns all state to reset values on the next edge;
  - the held beat is discarded;
  - last-served returns to NUM_REQ-1.

## Timing
- Request to grant: `i_req_vld` sampled in IDLE at edge N gives `o_grant` valid after edge N.
- First beat:
  - `o_req_rdy` is high during cycle N+1 if the stage is free;
  - the beat is accepted at edge N+1;
  - `o_fifo_wr` is high in cycle N+2.
- Steady burst throughput is 1 beat/cycle while `i_fifo_full`=0.
- Burst-to-burst gap is one idle cycle on `o_fifo_wr`.
- `o_req_rdy` depends combinationally on `i_fifo_full`, `o_fifo_wr` and state.
- All other outputs are registered.

## Test plan
- **Single requester:** requester 0 sends 3 beats 0xA,0xB,0xC with last on 0xC, FIFO not full -> `o_fifo_wr` high in cycles 2-4 carrying A,B,C; `o_grant`=0001 in cycles 1-3; then IDLE.
- **Round robin:** all 4 requesters always valid, bursts of 2 -> grant order 0,1,2,3,0; each burst gives 2 `o_fifo_wr` beats followed by a 1-cycle gap.
- **MAX_BURST cap:** MAX_BURST=8, requester 2 streams 20 beats with no last -> bursts of 8, 8, 4. With no other requester valid, requester 2 is re-granted after each 1-cycle IDLE gap.
- **Full stall:** `i_fifo_full` high for 5 cycles while `o_fifo_wr`=1 and data=0x55 -> data holds 0x55, `o_req_rdy`=0 and `o_stall_cnt` rises by 5. After release, beats continue in order with none lost or duplicated.
- **Almost full:** `i_fifo_a_full`=1 in IDLE with requests pending -> `o_grant` stays 0. Deasserting it gives a grant on the next edge. Asserting it mid-burst does not stall the burst.
- **Reset mid-burst:** `i_rst` pulsed during beat 3 of a 6-beat burst from requester 1 -> all outputs 0 after the edge. The next arbitration grants requester 0 if valid.
